// File: rtl/ace_ar_arbiter.sv
// ace_ar_arbiter: round-robin arbiter sharing one AR channel between N_CPU
// L1 controllers. The CPU index is appended to the MSHR id on the way out,
// and R beats are routed back to the owning CPU by that index. Per-CPU
// credit counters cap the number of reads each CPU has in flight.

// Per-CPU outstanding-read counter. It never wraps in either direction.
module ace_ar_credit #(
  parameter int MAX_OUTSTANDING = 1,
  parameter int CNT_W           = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic avail
);
  logic [CNT_W-1:0] cnt;

  assign avail = (cnt < CNT_W'(MAX_OUTSTANDING));

  // A grant and a last beat in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (inc && !dec && cnt != CNT_W'(MAX_OUTSTANDING))
      cnt <= cnt + CNT_W'(1);
    else if (dec && !inc && cnt != '0)
      cnt <= cnt - CNT_W'(1);
  end
endmodule

module ace_ar_arbiter #(
  parameter int N_CPU           = 2,
  parameter int MSHR_ID_WIDTH   = 1,
  parameter int CPU_ID_WIDTH    = $clog2(N_CPU),
  parameter int ID_WIDTH        = MSHR_ID_WIDTH + CPU_ID_WIDTH,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int AR_SNOOP_WIDTH  = 4,
  parameter int MAX_OUTSTANDING = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_CPU-1:0]                  s_ar_valid,
  output logic [N_CPU-1:0]                  s_ar_ready,
  input  logic [N_CPU*MSHR_ID_WIDTH-1:0]    s_ar_id,
  input  logic [N_CPU*ADDR_WIDTH-1:0]       s_ar_addr,
  input  logic [N_CPU*AR_SNOOP_WIDTH-1:0]   s_ar_snoop,
  output logic                              m_ar_valid,
  input  logic                              m_ar_ready,
  output logic [ID_WIDTH-1:0]               m_ar_id,
  output logic [ADDR_WIDTH-1:0]             m_ar_addr,
  output logic [AR_SNOOP_WIDTH-1:0]         m_ar_snoop,
  input  logic                              m_r_valid,
  output logic                              m_r_ready,
  input  logic [ID_WIDTH-1:0]               m_r_id,
  input  logic [DATA_WIDTH-1:0]             m_r_data,
  input  logic [3:0]                        m_r_resp,
  input  logic                              m_r_last,
  output logic [N_CPU-1:0]                  s_r_valid,
  input  logic [N_CPU-1:0]                  s_r_ready,
  output logic [MSHR_ID_WIDTH-1:0]          s_r_id,
  output logic [DATA_WIDTH-1:0]             s_r_data,
  output logic [3:0]                        s_r_resp,
  output logic                              s_r_last,
  output logic                              err_o
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_e;

  typedef struct packed {
    logic [MSHR_ID_WIDTH-1:0]  mshr;
    logic [CPU_ID_WIDTH-1:0]   cpu;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [AR_SNOOP_WIDTH-1:0] snoop;
  } ar_req_t;

  arb_state_e              state, state_nxt;
  ar_req_t                 ar_q;
  logic [CPU_ID_WIDTH-1:0] last_grant;
  logic [CPU_ID_WIDTH-1:0] grant_idx;
  logic                    grant_found;
  logic                    grant_fire;
  logic [N_CPU-1:0]        avail;
  logic [N_CPU-1:0]        eligible;
  logic [N_CPU-1:0]        r_last_fire;
  logic [CPU_ID_WIDTH-1:0] r_cpu;
  logic                    cpu_ok;

  assign eligible   = s_ar_valid & avail;
  assign grant_fire = (state == ARB_IDLE) && grant_found && !rst;

  // Rotating priority search starting just after the previous winner.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= N_CPU; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= N_CPU) idx = idx - N_CPU;
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant_idx   = CPU_ID_WIDTH'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

  // Next state and the same-cycle accept strobe toward the winning CPU.
  always_comb begin
    state_nxt  = state;
    s_ar_ready = '0;
    case (state)
      ARB_IDLE: begin
        if (grant_fire) begin
          s_ar_ready[grant_idx] = 1'b1;
          state_nxt             = ARB_HOLD;
        end
      end
      ARB_HOLD: begin
        if (m_ar_ready) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Output slice: captured on grant, frozen while HOLD waits for m_ar_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      ar_q       <= '0;
      last_grant <= CPU_ID_WIDTH'(N_CPU - 1);
    end else if (grant_fire) begin
      ar_q.mshr  <= s_ar_id[grant_idx*MSHR_ID_WIDTH +: MSHR_ID_WIDTH];
      ar_q.cpu   <= grant_idx;
      ar_q.addr  <= s_ar_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
      ar_q.snoop <= s_ar_snoop[grant_idx*AR_SNOOP_WIDTH +: AR_SNOOP_WIDTH];
      last_grant <= grant_idx;
    end
  end

  assign m_ar_valid = (state == ARB_HOLD);
  assign m_ar_id    = {ar_q.mshr, ar_q.cpu};
  assign m_ar_addr  = ar_q.addr;
  assign m_ar_snoop = ar_q.snoop;

  // R return path: route by the CPU index carried in the low id bits.
  assign r_cpu  = m_r_id[CPU_ID_WIDTH-1:0];
  assign cpu_ok = (int'(r_cpu) < N_CPU);

  // One-hot valid to the owning CPU; ready comes back from that CPU only.
  always_comb begin
    s_r_valid = '0;
    m_r_ready = 1'b1;
    if (cpu_ok) begin
      s_r_valid[r_cpu] = m_r_valid;
      m_r_ready        = s_r_ready[r_cpu];
    end
  end

  assign s_r_id   = m_r_id[ID_WIDTH-1:CPU_ID_WIDTH];
  assign s_r_data = m_r_data;
  assign s_r_resp = m_r_resp;
  assign s_r_last = m_r_last;

  // Sticky flag for beats carrying a CPU index that does not exist.
  always_ff @(posedge clk) begin
    if (rst)                       err_o <= 1'b0;
    else if (m_r_valid && !cpu_ok) err_o <= 1'b1;
  end

  assign r_last_fire = s_r_valid & s_r_ready & {N_CPU{m_r_last}};

  for (genvar i = 0; i < N_CPU; i++) begin : g_cpu
    ace_ar_credit #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .CNT_W           (CNT_W)
    ) u_credit (
      .clk   (clk),
      .rst   (rst),
      .inc   (s_ar_valid[i] & s_ar_ready[i]),
      .dec   (r_last_fire[i]),
      .avail (avail[i])
    );
  end
endmodule

// File: tb/tb_ace_ar_arbiter.sv
// Bench for ace_ar_arbiter: three instances (N=2/MAX=1, N=2/MAX=4, N=3/MAX=1),
// table-driven R routing vectors plus hand-written AR sequences, with
// scoreboards for AR payloads and R data order on the main instance.
module tb_ace_ar_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance (N_CPU=2, MAX_OUTSTANDING=1) and shared stimulus.
  logic [1:0]  ar_valid, ar_ready, ar_id;
  logic [63:0] ar_addr;
  logic [7:0]  ar_snoop;
  logic        m_ar_valid, m_ar_ready;
  logic [1:0]  m_ar_id;
  logic [31:0] m_ar_addr;
  logic [3:0]  m_ar_snoop;
  logic        m_r_valid, m_r_ready, m_r_last;
  logic [1:0]  m_r_id;
  logic [31:0] m_r_data;
  logic [3:0]  m_r_resp;
  logic [1:0]  s_r_valid, s_r_ready;
  logic        s_r_id, s_r_last, err;
  logic [31:0] s_r_data;
  logic [3:0]  s_r_resp;

  // MAX_OUTSTANDING=4 instance.
  logic [1:0]  b_ar_valid, b_ar_ready, b_m_ar_id, b_s_r_valid;
  logic        b_m_ar_valid, b_m_ar_ready, b_m_r_ready, b_s_r_id, b_s_r_last, b_err;
  logic [31:0] b_m_ar_addr, b_s_r_data;
  logic [3:0]  b_m_ar_snoop, b_s_r_resp;

  // N_CPU=3 instance.
  logic [2:0]  c_ar_valid, c_ar_ready, c_ar_id, c_m_r_id, c_s_r_valid, c_s_r_ready, c_m_ar_id;
  logic [95:0] c_ar_addr;
  logic [11:0] c_ar_snoop;
  logic        c_m_ar_valid, c_m_r_valid, c_m_r_ready, c_s_r_id, c_s_r_last, c_err;
  logic [31:0] c_m_ar_addr, c_s_r_data;
  logic [3:0]  c_m_ar_snoop, c_s_r_resp;

  ace_ar_arbiter #(.N_CPU(2), .MAX_OUTSTANDING(1)) u_dut (
    .clk(clk), .rst(rst),
    .s_ar_valid(ar_valid), .s_ar_ready(ar_ready), .s_ar_id(ar_id),
    .s_ar_addr(ar_addr), .s_ar_snoop(ar_snoop),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_id(m_ar_id),
    .m_ar_addr(m_ar_addr), .m_ar_snoop(m_ar_snoop),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_id(m_r_id),
    .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_last(m_r_last),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_id(s_r_id),
    .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_last(s_r_last),
    .err_o(err)
  );

  ace_ar_arbiter #(.N_CPU(2), .MAX_OUTSTANDING(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .s_ar_valid(b_ar_valid), .s_ar_ready(b_ar_ready), .s_ar_id(ar_id),
    .s_ar_addr(ar_addr), .s_ar_snoop(ar_snoop),
    .m_ar_valid(b_m_ar_valid), .m_ar_ready(b_m_ar_ready), .m_ar_id(b_m_ar_id),
    .m_ar_addr(b_m_ar_addr), .m_ar_snoop(b_m_ar_snoop),
    .m_r_valid(m_r_valid), .m_r_ready(b_m_r_ready), .m_r_id(m_r_id),
    .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_last(m_r_last),
    .s_r_valid(b_s_r_valid), .s_r_ready(s_r_ready), .s_r_id(b_s_r_id),
    .s_r_data(b_s_r_data), .s_r_resp(b_s_r_resp), .s_r_last(b_s_r_last),
    .err_o(b_err)
  );

  ace_ar_arbiter #(.N_CPU(3), .MAX_OUTSTANDING(1)) u_dut3 (
    .clk(clk), .rst(rst),
    .s_ar_valid(c_ar_valid), .s_ar_ready(c_ar_ready), .s_ar_id(c_ar_id),
    .s_ar_addr(c_ar_addr), .s_ar_snoop(c_ar_snoop),
    .m_ar_valid(c_m_ar_valid), .m_ar_ready(1'b1), .m_ar_id(c_m_ar_id),
    .m_ar_addr(c_m_ar_addr), .m_ar_snoop(c_m_ar_snoop),
    .m_r_valid(c_m_r_valid), .m_r_ready(c_m_r_ready), .m_r_id(c_m_r_id),
    .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_last(m_r_last),
    .s_r_valid(c_s_r_valid), .s_r_ready(c_s_r_ready), .s_r_id(c_s_r_id),
    .s_r_data(c_s_r_data), .s_r_resp(c_s_r_resp), .s_r_last(c_s_r_last),
    .err_o(c_err)
  );

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] addr;
    logic [3:0]  snoop;
  } arexp_t;

  typedef struct {
    logic       vld;
    logic [1:0] id;
    logic [7:0] dat;
    logic       last;
    logic [1:0] rdy;
    logic [1:0] exp_sv;
    logic       exp_mr;
  } rvec_t;

  arexp_t      ar_q[$];
  logic [31:0] r_q[$];
  int          nvec = 0;
  int          nerr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_r(input logic vld, input logic [1:0] id, input logic [31:0] d,
                         input logic last, input logic [1:0] rdy);
    m_r_valid = vld;
    m_r_id    = id;
    m_r_data  = d;
    m_r_last  = last;
    s_r_ready = rdy;
    if (vld && rdy[id[0]]) r_q.push_back(d);
  endtask

  // Scoreboards: AR payloads on downstream handshake, R data on upstream handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_ar_valid && m_ar_ready) begin
        if (ar_q.size() == 0) check("ar_sb_unexpected", 1, 0);
        else begin
          arexp_t e;
          e = ar_q.pop_front();
          check("ar_sb_id", m_ar_id, e.id);
          check("ar_sb_addr", m_ar_addr, e.addr);
          check("ar_sb_snoop", m_ar_snoop, e.snoop);
        end
      end
      if (|(s_r_valid & s_r_ready)) begin
        if (r_q.size() == 0) check("r_sb_unexpected", 1, 0);
        else check("r_sb_data", s_r_data, r_q.pop_front());
      end
    end
  end

  rvec_t      rv[10];
  logic [1:0] fair_rdy[8];
  logic [1:0] fair_id[8];

  initial begin
    int b, g;
    b = 0;
    for (int v = 0; v < 10; v++) begin
      logic stall;
      stall = (v == 4 || v == 5);
      rv[v] = '{1'b1, 2'b11, 8'(8'hA0 + b), (b == 7), stall ? 2'b00 : 2'b10, 2'b10, !stall};
      if (!stall) b++;
    end
    fair_rdy = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    fair_id  = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11};

    rst = 1'b1;
    ar_valid = 2'b11; b_ar_valid = 2'b11; c_ar_valid = '0;
    ar_id = 2'b10; ar_addr = {32'h0000_2000, 32'h0000_1000}; ar_snoop = 8'h00;
    c_ar_id = '0; c_ar_addr = '0; c_ar_snoop = '0;
    m_ar_ready = 1'b0; b_m_ar_ready = 1'b0;
    m_r_resp = 4'h0;
    drive_r(1'b0, 2'b00, 32'h0, 1'b0, 2'b00);
    c_m_r_valid = 1'b0; c_m_r_id = '0; c_s_r_ready = '0;
    step(); step();

    // Reset state: no accept even with requests pending.
    @(negedge clk);
    check("rst_ar_ready", ar_ready, 2'b00);
    check("rst_m_ar_valid", m_ar_valid, 1'b0);
    check("rst_b_ar_ready", b_ar_ready, 2'b00);
    check("rst_err", err, 1'b0);
    check("rst_c_err", c_err, 1'b0);
    rst = 1'b0; ar_valid = 2'b00; b_ar_valid = 2'b00;
    step();

    // Fairness on MAX=4 instance: grant order 0,1,0,1, one per 2 cycles.
    b_ar_valid = 2'b11; b_m_ar_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("fair_ready", b_ar_ready, fair_rdy[k]);
      if (k % 2 == 1) check("fair_m_ar_id", b_m_ar_id, fair_id[k]);
      step();
    end

    // Grant and last beat for CPU0 together: count stays 2, so 2 more grants fit.
    b_ar_valid = 2'b01;
    drive_r(1'b1, 2'b00, 32'hB0, 1'b1, 2'b01);
    @(negedge clk);
    check("simul_ready", b_ar_ready, 2'b01);
    step();
    drive_r(1'b0, 2'b00, 32'h0, 1'b0, 2'b00);
    g = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (b_ar_ready[0]) g++;
      step();
    end
    check("simul_credit_grants", g, 2);
    b_ar_valid = 2'b00;
    rst = 1'b1; step(); rst = 1'b0;
    ar_q.delete(); r_q.delete();

    // Single request from CPU1, held for 3 cycles of backpressure.
    ar_valid = 2'b10; ar_id = 2'b00;
    ar_addr = {32'h0000_1040, 32'h0000_0100}; ar_snoop = 8'h12;
    @(negedge clk);
    check("single_ready", ar_ready, 2'b10);
    ar_q.push_back('{2'b01, 32'h0000_1040, 4'b0001});
    step();
    ar_valid = 2'b01;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_valid", m_ar_valid, 1'b1);
      check("hold_id", m_ar_id, 2'b01);
      check("hold_addr", m_ar_addr, 32'h0000_1040);
      check("hold_no_ready", ar_ready, 2'b00);
      step();
    end
    ar_valid = 2'b00; m_ar_ready = 1'b1;
    step();
    m_ar_ready = 1'b0;
    @(negedge clk);
    check("back_idle", m_ar_valid, 1'b0);
    step();

    // R routing table with a 2-cycle stall mid-burst.
    for (int v = 0; v < 10; v++) begin
      drive_r(rv[v].vld, rv[v].id, {24'h0, rv[v].dat}, rv[v].last, rv[v].rdy);
      @(negedge clk);
      check("r_s_valid", s_r_valid, rv[v].exp_sv);
      check("r_m_ready", m_r_ready, rv[v].exp_mr);
      check("r_s_id", s_r_id, rv[v].id[1]);
      check("r_s_last", s_r_last, rv[v].last);
      step();
    end
    drive_r(1'b0, 2'b00, 32'h0, 1'b0, 2'b00);

    // Credit limit with MAX=1.
    m_ar_ready = 1'b1; ar_valid = 2'b01;
    @(negedge clk);
    check("cred_first", ar_ready, 2'b01);
    ar_q.push_back('{2'b00, 32'h0000_0100, 4'h2});
    step();
    ar_valid = 2'b11;
    @(negedge clk);
    check("cred_hold", ar_ready, 2'b00);
    step();
    @(negedge clk);
    check("cred_cpu0_blocked", ar_ready, 2'b10);
    ar_q.push_back('{2'b01, 32'h0000_1040, 4'h1});
    step(); step();
    drive_r(1'b1, 2'b00, 32'hC0, 1'b1, 2'b01);
    @(negedge clk);
    check("cred_both_full", ar_ready, 2'b00);
    step();
    drive_r(1'b0, 2'b00, 32'h0, 1'b0, 2'b00);
    m_ar_ready = 1'b0;
    @(negedge clk);
    check("cred_cpu0_again", ar_ready, 2'b01);
    ar_q.push_back('{2'b00, 32'h0000_0100, 4'h2});
    step();

    // Reset while holding: AR dropped, credits and priority restored.
    @(negedge clk);
    check("pre_rst_hold", m_ar_valid, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    ar_q.delete();
    @(negedge clk);
    check("rst_hold_valid", m_ar_valid, 1'b0);
    check("rst_hold_credit", ar_ready, 2'b01);
    ar_valid = 2'b00;
    step();

    // N_CPU=3: valid routing to CPU2, then a beat for nonexistent CPU3.
    c_m_r_valid = 1'b1; c_m_r_id = 3'b010; c_s_r_ready = 3'b100;
    @(negedge clk);
    check("n3_route", c_s_r_valid, 3'b100);
    check("n3_err_clear", c_err, 1'b0);
    step();
    c_m_r_id = 3'b011; c_s_r_ready = 3'b000;
    @(negedge clk);
    check("n3_bad_valid", c_s_r_valid, 3'b000);
    check("n3_bad_drain", c_m_r_ready, 1'b1);
    step();
    c_m_r_valid = 1'b0;
    @(negedge clk);
    check("n3_err_set", c_err, 1'b1);
    step();
    @(negedge clk);
    check("n3_err_sticky", c_err, 1'b1);

    check("r_sb_drained", r_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
